// File: rtl/qspi_master_reader.sv
// Quad-SPI read initiator: sends a quad read command and 8-bit address, waits out the
// turnaround clocks, then collects byte_cnt bytes and strobes each one out on rd_valid.
module qspi_master_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 2,
  parameter logic [7:0]  CMD_READ     = 8'h6B
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [8:0] byte_cnt,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       O_qspi_cs,
  output logic       O_qspi_clk,
  output logic [3:0] O_io_out,
  output logic       O_io_oe,
  input  logic [3:0] I_io_in
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 2) ? DUMMY_CYCLES : 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       bytesLeft_q, bytesLeft_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rdData_q, rdData_d;
  logic [3:0]       ioOut_q, ioOut_d;
  logic             cs_q, cs_d;
  logic             clk_q, clk_d;
  logic             oe_q, oe_d;
  logic             rdValid_q, rdValid_d;
  logic             halfEnd, rise, fall;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      divCnt_q    <= '0;
      cnt_q       <= '0;
      bytesLeft_q <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      rdData_q    <= '0;
      ioOut_q     <= '0;
      cs_q        <= 1'b1;
      clk_q       <= 1'b0;
      oe_q        <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      divCnt_q    <= divCnt_d;
      cnt_q       <= cnt_d;
      bytesLeft_q <= bytesLeft_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      rdData_q    <= rdData_d;
      ioOut_q     <= ioOut_d;
      cs_q        <= cs_d;
      clk_q       <= clk_d;
      oe_q        <= oe_d;
      rdValid_q   <= rdValid_d;
    end
  end

  // CS_SETUP doubles as the low half of the first command clock, so CMD starts high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bytesLeft_d = bytesLeft_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    rdData_d    = rdData_q;
    ioOut_d     = ioOut_q;
    cs_d        = cs_q;
    clk_d       = clk_q;
    oe_d        = oe_q;
    rdValid_d   = 1'b0;
    halfEnd     = (divCnt_q == DIV_LAST);
    rise        = halfEnd && !clk_q;
    fall        = halfEnd && clk_q;
    divCnt_d    = (halfEnd || state_q == IDLE || state_q == FINISH) ? '0 : divCnt_q + DIV_W'(1);

    if (halfEnd && (state_q == CMD || state_q == ADDR || state_q == DUMMY || state_q == DATA)) begin
      clk_d = ~clk_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (byte_cnt != 9'd0) begin
            state_d     = CS_SETUP;
            addr_d      = start_addr;
            bytesLeft_d = byte_cnt;
            cs_d        = 1'b0;
            oe_d        = 1'b1;
            ioOut_d     = CMD_READ[7:4];
            cnt_d       = '0;
          end else begin
            state_d = FINISH;
          end
        end
      end
      CS_SETUP: begin
        if (halfEnd) begin
          state_d = CMD;
          clk_d   = 1'b1;
        end
      end
      CMD: begin
        if (fall) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(1);
            ioOut_d = CMD_READ[3:0];
          end else begin
            state_d = ADDR;
            cnt_d   = '0;
            ioOut_d = addr_q[7:4];
          end
        end
      end
      ADDR: begin
        if (fall) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(1);
            ioOut_d = addr_q[3:0];
          end else begin
            oe_d    = 1'b0;
            ioOut_d = 4'h0;
            cnt_d   = '0;
            state_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
          end
        end
      end
      DUMMY: begin
        if (fall) begin
          if (cnt_q == DUMMY_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (rise) begin
          shift_d = {shift_q[3:0], I_io_in};
        end
        if (fall) begin
          cnt_d = (cnt_q == '0) ? CNT_W'(1) : '0;
          if (cnt_q != '0) begin
            rdValid_d   = 1'b1;
            rdData_d    = shift_q;
            bytesLeft_d = bytesLeft_q - 9'd1;
            if (bytesLeft_q == 9'd1) begin
              state_d = CS_HOLD;
              cnt_d   = '0;
            end
          end
        end
      end
      CS_HOLD: begin
        // First half keeps cs low with clk parked; second half is the minimum deselect.
        if (halfEnd) begin
          if (cnt_q == '0) begin
            cs_d  = 1'b1;
            cnt_d = CNT_W'(1);
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) && (state_q != FINISH);
  assign done       = (state_q == FINISH);
  assign rd_data    = rdData_q;
  assign rd_valid   = rdValid_q;
  assign O_qspi_cs  = cs_q;
  assign O_qspi_clk = clk_q;
  assign O_io_out   = ioOut_q;
  assign O_io_oe    = oe_q;

endmodule

// File: tb/tb_qspi_master_reader.sv
// Bench for qspi_master_reader: two instances (default timing and CLK_DIV=1/DUMMY=4),
// a byte-addressed slave RAM model, and timing/data expectations from cycle arithmetic.
module tb_qspi_master_reader;

  logic sclk;
  logic rst;
  logic [1:0]      startS   = '0;
  logic [1:0][7:0] addrS    = '0;
  logic [1:0][8:0] cntS     = '0;
  logic [1:0]      busyS, doneS, rdValidS, csS, qclkS, oeS;
  logic [1:0][7:0] rdDataS;
  logic [1:0][3:0] ioOutS;
  logic [1:0][3:0] ioInS    = '0;
  logic [1:0][7:0] cmdSeen  = '0;
  logic [1:0][7:0] addrSeen = '0;
  logic [1:0]      prevClk  = '0;
  int              edges[2];
  int              slvM;
  logic [7:0]      slvB;
  logic [7:0]      ram[256];
  int              nChecks;
  int              nErrors;

  qspi_master_reader #(.CLK_DIV(2), .DUMMY_CYCLES(2), .CMD_READ(8'h6B)) dut0 (
    .sclk(sclk), .rst(rst), .start(startS[0]), .start_addr(addrS[0]), .byte_cnt(cntS[0]),
    .busy(busyS[0]), .done(doneS[0]), .rd_data(rdDataS[0]), .rd_valid(rdValidS[0]),
    .O_qspi_cs(csS[0]), .O_qspi_clk(qclkS[0]), .O_io_out(ioOutS[0]), .O_io_oe(oeS[0]),
    .I_io_in(ioInS[0])
  );

  qspi_master_reader #(.CLK_DIV(1), .DUMMY_CYCLES(4), .CMD_READ(8'h6B)) dut1 (
    .sclk(sclk), .rst(rst), .start(startS[1]), .start_addr(addrS[1]), .byte_cnt(cntS[1]),
    .busy(busyS[1]), .done(doneS[1]), .rd_data(rdDataS[1]), .rd_valid(rdValidS[1]),
    .O_qspi_cs(csS[1]), .O_qspi_clk(qclkS[1]), .O_io_out(ioOutS[1]), .O_io_oe(oeS[1]),
    .I_io_in(ioInS[1])
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic int cdOf(input int inst);
    return (inst == 0) ? 2 : 1;
  endfunction

  function automatic int dOf(input int inst);
    return (inst == 0) ? 2 : 4;
  endfunction

  // Slave model: records command/address nibbles on rising QSPI clocks and presents
  // RAM data (8-bit wrapping address) on the falling edge before each data clock.
  always @(negedge sclk) begin
    for (int g = 0; g < 2; g++) begin
      if (csS[g]) begin
        edges[g] = 0;
      end else if (qclkS[g] && !prevClk[g]) begin
        if (edges[g] < 2) cmdSeen[g] = {cmdSeen[g][3:0], ioOutS[g]};
        else if (edges[g] < 4) addrSeen[g] = {addrSeen[g][3:0], ioOutS[g]};
        edges[g]++;
      end else if (!qclkS[g] && prevClk[g] && edges[g] >= 4 + dOf(g)) begin
        slvM = edges[g] - 4 - dOf(g);
        slvB = ram[8'((int'(addrSeen[g]) + slvM / 2) % 256)];
        ioInS[g] = (slvM % 2 == 0) ? slvB[7:4] : slvB[3:0];
      end
      prevClk[g] = qclkS[g];
    end
  end

  // Issues one request and checks every observable against cycle arithmetic; cycle 0 is
  // the cycle in which start is sampled. restartAt>0 pulses a stray start mid-transfer.
  task automatic runRead(input int inst, input logic [7:0] addr, input int n,
                         input int restartAt, input string tag);
    int cd, dc, expDone, expCyc, cyc, doneCyc, rises, busyErrs, oeErrs, extra, limit;
    bit csLow, prevQ;
    logic [7:0] expB;
    int vCyc[$];
    logic [7:0] vData[$];
    cd = cdOf(inst);
    dc = dOf(inst);
    expDone = (n == 0) ? 1 : 2 * cd * (4 + dc + 2 * n) + 2 * cd + 1;
    limit = expDone + 60;
    doneCyc = -1; rises = 0; busyErrs = 0; oeErrs = 0; extra = 0; csLow = 0; prevQ = 0;
    @(negedge sclk);
    startS[inst] = 1'b1;
    addrS[inst]  = addr;
    cntS[inst]   = 9'(n);
    @(negedge sclk);
    startS[inst] = 1'b0;
    cyc = 1;
    while (doneCyc < 0 && cyc <= limit) begin
      if (qclkS[inst] && !prevQ) rises++;
      prevQ = qclkS[inst];
      if (!csS[inst]) csLow = 1;
      if (rdValidS[inst]) begin
        vCyc.push_back(cyc);
        vData.push_back(rdDataS[inst]);
      end
      if (busyS[inst] !== (n > 0 && cyc < expDone)) busyErrs++;
      if (oeS[inst] && !csS[inst] && (rises > 4 || (rises == 4 && !qclkS[inst]))) oeErrs++;
      if (doneS[inst]) doneCyc = cyc;
      if (restartAt == cyc) begin
        startS[inst] = 1'b1;
        addrS[inst]  = addr + 8'h40;
        cntS[inst]   = 9'd3;
      end else begin
        startS[inst] = 1'b0;
      end
      @(negedge sclk);
      cyc++;
    end
    startS[inst] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!csS[inst] || rdValidS[inst] || doneS[inst] || busyS[inst]) extra++;
      @(negedge sclk);
    end

    nChecks++;
    if (doneCyc != expDone) begin
      nErrors++;
      $display("[TB] FAIL %s done_cycle: got %0d expected %0d", tag, doneCyc, expDone);
    end
    nChecks++;
    if (vCyc.size() != n) begin
      nErrors++;
      $display("[TB] FAIL %s byte_count: got %0d expected %0d", tag, vCyc.size(), n);
    end
    for (int k = 0; k < vCyc.size() && k < n; k++) begin
      expB = ram[8'((int'(addr) + k) % 256)];
      expCyc = 2 * cd * (6 + dc + 2 * k) + 1;
      nChecks++;
      if (vData[k] !== expB) begin
        nErrors++;
        $display("[TB] FAIL %s rd_data[%0d]: got %h expected %h", tag, k, vData[k], expB);
      end
      nChecks++;
      if (vCyc[k] != expCyc) begin
        nErrors++;
        $display("[TB] FAIL %s rd_valid_cycle[%0d]: got %0d expected %0d", tag, k, vCyc[k], expCyc);
      end
    end
    nChecks++;
    if (busyErrs != 0) begin
      nErrors++;
      $display("[TB] FAIL %s busy_profile: got %0d bad cycles expected 0", tag, busyErrs);
    end
    nChecks++;
    if (extra != 0) begin
      nErrors++;
      $display("[TB] FAIL %s idle_after_done: got %0d active cycles expected 0", tag, extra);
    end
    if (n > 0) begin
      nChecks++;
      if (rises != 4 + dc + 2 * n) begin
        nErrors++;
        $display("[TB] FAIL %s qspi_clk_rises: got %0d expected %0d", tag, rises, 4 + dc + 2 * n);
      end
      nChecks++;
      if (cmdSeen[inst] !== 8'h6B) begin
        nErrors++;
        $display("[TB] FAIL %s command: got %h expected 6b", tag, cmdSeen[inst]);
      end
      nChecks++;
      if (addrSeen[inst] !== addr) begin
        nErrors++;
        $display("[TB] FAIL %s address: got %h expected %h", tag, addrSeen[inst], addr);
      end
      nChecks++;
      if (oeErrs != 0) begin
        nErrors++;
        $display("[TB] FAIL %s oe_after_addr: got %0d driven cycles expected 0", tag, oeErrs);
      end
    end else begin
      nChecks++;
      if (csLow) begin
        nErrors++;
        $display("[TB] FAIL %s cs_fell: got 1 expected 0", tag);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sclk);
    for (int i = 0; i < 2; i++) begin
      nChecks++;
      if ({csS[i], qclkS[i], oeS[i], ioOutS[i], busyS[i], doneS[i], rdValidS[i], rdDataS[i]}
          !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
        nErrors++;
        $display("[TB] FAIL reset_values[%0d]: got cs=%b clk=%b oe=%b io=%h busy=%b done=%b v=%b d=%h expected cs=1 others 0",
                 i, csS[i], qclkS[i], oeS[i], ioOutS[i], busyS[i], doneS[i], rdValidS[i], rdDataS[i]);
      end
    end
    rst = 1'b0;
    @(negedge sclk);
  endtask

  task automatic test_single_byte();
    ram[8'h10] = 8'hA5;
    runRead(0, 8'h10, 1, 0, "single");
  endtask

  task automatic test_aes_block();
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    runRead(0, 8'h00, 16, 0, "aes16");
  endtask

  task automatic test_wrap();
    ram[8'hFE] = 8'h11; ram[8'hFF] = 8'h22; ram[8'h00] = 8'h33; ram[8'h01] = 8'h44;
    runRead(0, 8'hFE, 4, 0, "wrap");
  endtask

  task automatic test_zero_count();
    runRead(0, 8'h55, 0, 0, "zero0");
    runRead(1, 8'h55, 0, 0, "zero1");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    runRead(0, 8'h20, 4, 15, "busy_ignore");
    runRead(1, 8'h70, 3, 9, "busy_ignore_fast");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge sclk);
    startS[0] = 1'b1; addrS[0] = 8'h30; cntS[0] = 9'd16;
    @(negedge sclk);
    startS[0] = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge sclk);
    nChecks++;
    if (csS[0] !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_active: got cs=%b expected 0", csS[0]);
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if ({csS[0], qclkS[0], oeS[0], busyS[0]} !== 4'b1000) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_abort: got cs=%b clk=%b oe=%b busy=%b expected 1 0 0 0",
               csS[0], qclkS[0], oeS[0], busyS[0]);
    end
    @(negedge sclk);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (doneS[0] || rdValidS[0] || !csS[0]) bad++;
      @(negedge sclk);
    end
    nChecks++;
    if (bad != 0) begin
      nErrors++;
      $display("[TB] FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
    end
    runRead(0, 8'h33, 1, 0, "post_reset");
  endtask

  task automatic test_fast_clock();
    runRead(1, 8'h80, 2, 0, "fast");
  endtask

  task automatic test_random();
    int inst, n;
    logic [7:0] addr;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      inst = int'($urandom_range(0, 1));
      n    = int'($urandom_range(1, 24));
      addr = 8'($urandom);
      runRead(inst, addr, n, 0, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    nChecks = 0;
    nErrors = 0;
    test_reset();
    test_single_byte();
    test_aes_block();
    test_wrap();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_fast_clock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
